channel_sweep_ctrl: RTL and testbench
=====================================

CHANNEL_SWEEP_CTRL -- requirements
Module: channel_sweep_ctrl

Interface
REQ-001 Parameter DWIDTH, default 16: width of the monitored channel output samples.
REQ-002 Parameter SNR_WIDTH, default 11: width of the signed Q10 noise scale driven to the channel.
REQ-003 Parameter CNT_WIDTH, default 16: width of the settle, measure and saturation counters.
REQ-004 Parameter STEP_WIDTH, default 6: width of the step count and step index.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request to begin a sweep; honoured only in IDLE.
REQ-008 abort  in  1  terminate the sweep immediately.
REQ-009 sigma_start  in  SNR_WIDTH-1  unsigned first noise scale.
REQ-010 sigma_step  in  SNR_WIDTH-1  unsigned increment per step.
REQ-011 num_steps  in  STEP_WIDTH  number of sweep steps; 0 is treated as 1.
REQ-012 settle_len  in  CNT_WIDTH  valid samples discarded after each sigma change.
REQ-013 meas_len  in  CNT_WIDTH  valid samples measured per step; 0 is treated as 1.
REQ-014 sample_valid  in  1  the channel produced a new Out_I/Out_Q pair this cycle.
REQ-015 Out_I, Out_Q  in  DWIDTH each  signed channel outputs being monitored.
REQ-016 sigma_scale  out  SNR_WIDTH  signed noise scale to the channel; always in 0..2^(SNR_WIDTH-1)-1.
REQ-017 busy, meas_en  out  1 each  sweep in progress; current sample lies in the measurement window.
REQ-018 step_done, done  out  1 each  single-cycle pulses marking end of step and end of sweep.
REQ-019 step_idx  out  STEP_WIDTH  index of the current or just-finished step.
REQ-020 sat_count  out  CNT_WIDTH  saturated-sample count of the last finished step.

Function
REQ-021 States SHALL be IDLE, SETTLE, MEASURE, NEXT and FINISH, registered and one-hot or binary.
REQ-022 In IDLE, start=1 with abort=0 SHALL latch all configuration inputs, load sigma_scale=sigma_start, set step_idx=0 and busy=1, and enter SETTLE on the next edge.
REQ-023 Configuration inputs SHALL be ignored outside the start cycle.
REQ-024 SETTLE SHALL count sample_valid cycles and enter MEASURE after settle_len of them; when settle_len=0 it SHALL pass to MEASURE after one cycle.
REQ-025 MEASURE SHALL assert meas_en and count sample_valid cycles, leaving after the effective meas_len-th valid sample.
REQ-026 In MEASURE, a valid sample SHALL increment an internal saturation counter when Out_I or Out_Q equals 2^(DWIDTH-1)-1 or -2^(DWIDTH-1).
REQ-027 The saturation counter SHALL stick at all-ones rather than wrap, and SHALL clear on entry to every SETTLE.
REQ-028 On leaving MEASURE, the block SHALL copy the counter (including the final sample) to sat_count and pulse step_done in NEXT.
REQ-029 From NEXT with step_idx = effective num_steps-1, the block SHALL go to FINISH; otherwise it SHALL increment step_idx, add sigma_step to sigma_scale and return to SETTLE.
REQ-030 A sigma sum exceeding 2^(SNR_WIDTH-1)-1 SHALL clamp at that value; subsequent steps SHALL hold the clamp.
REQ-031 FINISH SHALL pulse done for one cycle, drive sigma_scale=0 and busy=0, and return to IDLE; step_idx and sat_count SHALL hold their values.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with sigma_scale=0, busy=0 and meas_en=0, with no step_done or done pulse.
REQ-033 abort SHALL have priority over start and over all counter events in the same cycle.
REQ-034 start asserted while busy SHALL be ignored.
REQ-035 Cycles without sample_valid SHALL freeze the settle and measure counters.

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE, sigma_scale=0, busy=0, meas_en=0, step_done=0, done=0, step_idx=0, sat_count=0 and all counters to 0, including in the middle of a sweep.

Verification
REQ-037 start with sigma_start=512, sigma_step=0, num_steps=1, settle_len=4, meas_len=8 and sample_valid held high -> busy rises 1 cycle after start, meas_en is high for 8 cycles, then step_done, then done, then sigma_scale=0.
REQ-038 num_steps=3, sigma_start=900, sigma_step=100 -> sigma_scale sequence 900, 1000, 1023, with step_idx 0, 1, 2.
REQ-039 Out_I=32767 on 3 of 8 measured samples and Out_Q=-32768 on 1 other -> sat_count=4 at step_done; saturated samples during SETTLE are not counted.
REQ-040 sample_valid toggled every other cycle with meas_len=8 -> meas_en spans 16 cycles.
REQ-041 abort raised in MEASURE of step 1 together with start -> IDLE next cycle, sigma_scale=0, no done pulse; a fresh start is accepted afterwards.
REQ-042 rst pulsed mid-SETTLE between clock edges -> outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/channel_sweep_if.sv
// Control/status bundle between a sweep controller and the channel it drives.
// The master side owns start, configuration and channel samples; the slave side is the controller.
interface channel_sweep_if #(
    parameter int DWIDTH     = 16,
    parameter int SNR_WIDTH  = 11,
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 6
);
    logic                         start;
    logic                         abort;
    logic [SNR_WIDTH-2:0]         sigma_start;
    logic [SNR_WIDTH-2:0]         sigma_step;
    logic [STEP_WIDTH-1:0]        num_steps;
    logic [CNT_WIDTH-1:0]         settle_len;
    logic [CNT_WIDTH-1:0]         meas_len;
    logic                         sample_valid;
    logic signed [DWIDTH-1:0]     Out_I;
    logic signed [DWIDTH-1:0]     Out_Q;
    logic signed [SNR_WIDTH-1:0]  sigma_scale;
    logic                         busy;
    logic                         meas_en;
    logic                         step_done;
    logic                         done;
    logic [STEP_WIDTH-1:0]        step_idx;
    logic [CNT_WIDTH-1:0]         sat_count;

    modport master (
        output start, abort, sigma_start, sigma_step, num_steps, settle_len, meas_len,
               sample_valid, Out_I, Out_Q,
        input  sigma_scale, busy, meas_en, step_done, done, step_idx, sat_count
    );

    modport slave (
        input  start, abort, sigma_start, sigma_step, num_steps, settle_len, meas_len,
               sample_valid, Out_I, Out_Q,
        output sigma_scale, busy, meas_en, step_done, done, step_idx, sat_count
    );
endinterface

// File: rtl/channel_sweep_ctrl.sv
// Steps the channel noise scale through a programmed ramp, settling and then counting
// saturated output samples at each step.
module channel_sweep_ctrl #(
    parameter int DWIDTH     = 16,
    parameter int SNR_WIDTH  = 11,
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    channel_sweep_if.slave bus
);
    localparam int unsigned SW = SNR_WIDTH - 1;
    localparam logic [DWIDTH-1:0] SAT_POS = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] SAT_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_NEXT, S_FINISH} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sigma_q, sigma_d;
    logic [SW-1:0]         sigma_step_q, sigma_step_d;
    logic [STEP_WIDTH-1:0] num_steps_q, num_steps_d;
    logic [CNT_WIDTH-1:0]  settle_len_q, settle_len_d;
    logic [CNT_WIDTH-1:0]  meas_len_q, meas_len_d;
    logic [CNT_WIDTH-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_WIDTH-1:0]  meas_cnt_q, meas_cnt_d;
    logic [CNT_WIDTH-1:0]  sat_cnt_q, sat_cnt_d;
    logic [CNT_WIDTH-1:0]  sat_count_q, sat_count_d;
    logic [STEP_WIDTH-1:0] step_idx_q, step_idx_d;
    logic                  busy_q, busy_d;
    logic                  meas_en_q, meas_en_d;
    logic                  step_done_q, step_done_d;
    logic                  done_q, done_d;

    logic                  sat_hit;
    logic [CNT_WIDTH-1:0]  sat_new;
    logic [CNT_WIDTH-1:0]  meas_last;
    logic [STEP_WIDTH-1:0] step_last;
    logic [SW:0]           sigma_sum;
    logic [SW-1:0]         sigma_next;

    // Next-state and datapath; abort is tested first so it beats every counter event.
    always_comb begin
        state_d      = state_q;
        sigma_d      = sigma_q;
        sigma_step_d = sigma_step_q;
        num_steps_d  = num_steps_q;
        settle_len_d = settle_len_q;
        meas_len_d   = meas_len_q;
        settle_cnt_d = settle_cnt_q;
        meas_cnt_d   = meas_cnt_q;
        sat_cnt_d    = sat_cnt_q;
        sat_count_d  = sat_count_q;
        step_idx_d   = step_idx_q;

        sat_hit = bus.sample_valid &&
                  (bus.Out_I == SAT_POS || bus.Out_I == SAT_NEG ||
                   bus.Out_Q == SAT_POS || bus.Out_Q == SAT_NEG);
        sat_new = (sat_hit && !(&sat_cnt_q)) ? sat_cnt_q + CNT_WIDTH'(1) : sat_cnt_q;
        meas_last = (meas_len_q == '0) ? '0 : meas_len_q - CNT_WIDTH'(1);
        step_last = (num_steps_q == '0) ? '0 : num_steps_q - STEP_WIDTH'(1);
        sigma_sum = {1'b0, sigma_q} + {1'b0, sigma_step_q};
        // A carry out of the SW-bit sum means the largest positive scale was exceeded.
        sigma_next = sigma_sum[SW] ? '1 : sigma_sum[SW-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    sigma_d      = bus.sigma_start;
                    sigma_step_d = bus.sigma_step;
                    num_steps_d  = bus.num_steps;
                    settle_len_d = bus.settle_len;
                    meas_len_d   = bus.meas_len;
                    step_idx_d   = '0;
                    settle_cnt_d = '0;
                    sat_cnt_d    = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (settle_len_q == '0) begin
                    meas_cnt_d = '0;
                    state_d    = S_MEASURE;
                end else if (bus.sample_valid) begin
                    if (settle_cnt_q == settle_len_q - CNT_WIDTH'(1)) begin
                        meas_cnt_d = '0;
                        state_d    = S_MEASURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_MEASURE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.sample_valid) begin
                    sat_cnt_d = sat_new;
                    if (meas_cnt_q == meas_last) begin
                        sat_count_d = sat_new;
                        state_d     = S_NEXT;
                    end else begin
                        meas_cnt_d = meas_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_NEXT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (step_idx_q == step_last) begin
                    state_d = S_FINISH;
                end else begin
                    step_idx_d   = step_idx_q + STEP_WIDTH'(1);
                    sigma_d      = sigma_next;
                    settle_cnt_d = '0;
                    sat_cnt_d    = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE || state_d == S_FINISH) sigma_d = '0;
        busy_d      = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_NEXT);
        meas_en_d   = (state_d == S_MEASURE);
        step_done_d = (state_d == S_NEXT);
        done_d      = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sigma_q      <= '0;
            sigma_step_q <= '0;
            num_steps_q  <= '0;
            settle_len_q <= '0;
            meas_len_q   <= '0;
            settle_cnt_q <= '0;
            meas_cnt_q   <= '0;
            sat_cnt_q    <= '0;
            sat_count_q  <= '0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            meas_en_q    <= 1'b0;
            step_done_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sigma_q      <= sigma_d;
            sigma_step_q <= sigma_step_d;
            num_steps_q  <= num_steps_d;
            settle_len_q <= settle_len_d;
            meas_len_q   <= meas_len_d;
            settle_cnt_q <= settle_cnt_d;
            meas_cnt_q   <= meas_cnt_d;
            sat_cnt_q    <= sat_cnt_d;
            sat_count_q  <= sat_count_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            meas_en_q    <= meas_en_d;
            step_done_q  <= step_done_d;
            done_q       <= done_d;
        end
    end

    assign bus.sigma_scale = {1'b0, sigma_q};
    assign bus.busy        = busy_q;
    assign bus.meas_en     = meas_en_q;
    assign bus.step_done   = step_done_q;
    assign bus.done        = done_q;
    assign bus.step_idx    = step_idx_q;
    assign bus.sat_count   = sat_count_q;
endmodule

// File: tb/tb_channel_sweep_ctrl.sv
// Directed bench for channel_sweep_ctrl; per-step results are scoreboarded and
// checked whenever step_done pulses.
module tb_channel_sweep_ctrl;
    typedef struct {
        int idx;
        int sat;
        int sigma;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    channel_sweep_if bus ();

    channel_sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int sat, input int sigma);
        exp_t e;
        e.idx   = idx;
        e.sat   = sat;
        e.sigma = sigma;
        sb.push_back(e);
    endtask

    // Present configuration with start for one cycle, then scramble it to prove it was latched.
    task automatic do_start(input int ss, input int st, input int ns, input int sl, input int ml);
        bus.sigma_start = 10'(ss);
        bus.sigma_step  = 10'(st);
        bus.num_steps   = 6'(ns);
        bus.settle_len  = 16'(sl);
        bus.meas_len    = 16'(ml);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.sigma_start = 10'd3;
        bus.sigma_step  = 10'd1000;
        bus.num_steps   = 6'd63;
        bus.settle_len  = 16'd500;
        bus.meas_len    = 16'd500;
    endtask

    // Cycle k = 0 is the first cycle after the start edge; mode selects the input pattern.
    task automatic run_sweep(input int mode, output int meas_cyc, output int steps,
                             output int sd_k, output int done_k);
        meas_cyc = 0;
        steps    = 0;
        sd_k     = -1;
        done_k   = -1;
        for (int k = 0; k < 2000 && done_k < 0; k++) begin
            if (bus.meas_en) meas_cyc++;
            if (bus.step_done) begin
                steps++;
                sd_k = k;
            end
            if (bus.done) begin
                done_k = k;
                chk("done_sigma_zero", 32'(bus.sigma_scale), 0);
                chk("done_busy_low", 32'(bus.busy), 0);
            end else begin
                bus.sample_valid = (mode == 2) ? ((k % 2) == 1) : 1'b1;
                bus.Out_I = (mode == 1 && (k == 1 || k == 4 || k == 6 || k == 9)) ? 16'sh7FFF : 16'sh0011;
                bus.Out_Q = (mode == 1 && (k == 2 || k == 10)) ? 16'sh8000 : -16'sh0022;
                bus.start = (mode == 4 && k == 5);
                if (mode == 4 && k == 5) begin
                    bus.sigma_start = 10'd5;
                    bus.num_steps   = 6'd1;
                end
                tick();
            end
        end
        bus.start = 1'b0;
        chk("sweep_timeout", 32'(done_k >= 0), 1);
    endtask

    // Scoreboard check of every finished step.
    always @(negedge clk) begin
        if (!rst && bus.step_done) begin
            chk("sb_underflow", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("step_idx", 32'(bus.step_idx), 32'(e.idx));
                chk("sat_count", 32'(bus.sat_count), 32'(e.sat));
                chk("step_sigma", 32'(bus.sigma_scale), 32'(e.sigma));
            end
        end
    end

    initial begin
        int mc, st, sdk, dk, found, pulses;
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sigma_start = '0;
        bus.sigma_step = '0;
        bus.num_steps = '0;
        bus.settle_len = '0;
        bus.meas_len = '0;
        bus.sample_valid = 1'b0;
        bus.Out_I = '0;
        bus.Out_Q = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_sigma", 32'(bus.sigma_scale), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_meas_en", 32'(bus.meas_en), 0);
        chk("rst_step_done", 32'(bus.step_done), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_step_idx", 32'(bus.step_idx), 0);
        chk("rst_sat_count", 32'(bus.sat_count), 0);

        // Single step: settle 4, measure 8, continuous samples.
        push(0, 0, 512);
        do_start(512, 0, 1, 4, 8);
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("sigma_after_start", 32'(bus.sigma_scale), 512);
        chk("meas_en_in_settle", 32'(bus.meas_en), 0);
        run_sweep(0, mc, st, sdk, dk);
        chk("basic_meas_cycles", 32'(mc), 8);
        chk("basic_steps", 32'(st), 1);
        chk("basic_step_done_k", 32'(sdk), 12);
        chk("basic_done_k", 32'(dk), 13);
        tick();
        chk("idle_after_done", 32'(bus.busy), 0);

        // Saturation counting; hits during settle are ignored.
        push(0, 4, 300);
        do_start(300, 7, 1, 4, 8);
        run_sweep(1, mc, st, sdk, dk);
        chk("sat_done_k", 32'(dk), 13);
        tick();
        tick();
        chk("sat_count_hold", 32'(bus.sat_count), 4);
        chk("step_idx_hold", 32'(bus.step_idx), 0);

        // Ramp with clamp and hold; a start mid-sweep must be ignored.
        push(0, 0, 900);
        push(1, 0, 1000);
        push(2, 0, 1023);
        push(3, 0, 1023);
        do_start(900, 100, 4, 2, 3);
        run_sweep(4, mc, st, sdk, dk);
        chk("ramp_steps", 32'(st), 4);
        chk("ramp_meas_cycles", 32'(mc), 12);
        chk("ramp_done_k", 32'(dk), 24);
        tick();
        chk("ramp_step_idx_hold", 32'(bus.step_idx), 3);

        // Sparse samples stretch the measurement window.
        push(0, 0, 7);
        do_start(7, 0, 1, 2, 8);
        run_sweep(2, mc, st, sdk, dk);
        chk("sparse_meas_cycles", 32'(mc), 16);
        chk("sparse_done_k", 32'(dk), 21);
        tick();

        // Zero step count, zero measure and zero settle lengths.
        push(0, 0, 1023);
        do_start(1023, 5, 0, 0, 0);
        run_sweep(0, mc, st, sdk, dk);
        chk("zero_meas_cycles", 32'(mc), 1);
        chk("zero_steps", 32'(st), 1);
        chk("zero_done_k", 32'(dk), 3);
        tick();

        // Abort together with start during the second measurement window.
        push(0, 0, 100);
        do_start(100, 50, 3, 1, 4);
        bus.sample_valid = 1'b1;
        bus.Out_I = '0;
        bus.Out_Q = '0;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            if (bus.meas_en && bus.step_idx == 6'd1) found = 1;
            else tick();
        end
        chk("abort_window_reached", 32'(found), 1);
        chk("abort_window_sigma", 32'(bus.sigma_scale), 150);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.sigma_start = 10'd300;
        bus.num_steps = 6'd1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_sigma", 32'(bus.sigma_scale), 0);
        chk("abort_meas_en", 32'(bus.meas_en), 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            pulses += int'(bus.done) + int'(bus.step_done) + int'(bus.busy);
            tick();
        end
        chk("abort_quiet", 32'(pulses), 0);
        push(0, 0, 300);
        do_start(300, 0, 1, 1, 2);
        chk("restart_busy", 32'(bus.busy), 1);
        run_sweep(0, mc, st, sdk, dk);
        chk("restart_steps", 32'(st), 1);
        tick();

        // Asynchronous reset in the second step's settle window.
        push(0, 2, 200);
        do_start(200, 10, 3, 2, 2);
        bus.sample_valid = 1'b1;
        bus.Out_I = 16'sh7FFF;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (bus.busy && !bus.meas_en && !bus.step_done && bus.step_idx == 6'd1) found = 1;
            else tick();
        end
        chk("rst_window_reached", 32'(found), 1);
        chk("pre_rst_sigma", 32'(bus.sigma_scale), 210);
        chk("pre_rst_sat_count", 32'(bus.sat_count), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sigma", 32'(bus.sigma_scale), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_step_idx", 32'(bus.step_idx), 0);
        chk("async_rst_sat_count", 32'(bus.sat_count), 0);
        chk("async_rst_meas_en", 32'(bus.meas_en), 0);
        #1 rst = 1'b0;
        bus.Out_I = '0;
        tick();
        chk("post_rst_idle", 32'(bus.busy), 0);
        chk("sb_drain", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
